multdiv_divider: RTL and testbench
==================================

// Module: multdiv_divider
// PURPOSE
//  - Multicycle signed integer divider; the division counterpart of the multiplier datapath in multdiv.
//  - Shift-subtract restoring algorithm on operand magnitudes, one quotient bit per cycle, then sign fixup.
//  - Sits beside the multiplier under the multdiv wrapper, which routes ctrl_DIV and muxes results.
// PARAMETERS
//  - WIDTH  32  operand/quotient width; counter width = $clog2(WIDTH)+1
// PORTS
//  - clock            in   1      sole clock, rising edge
//  - reset_n          in   1      asynchronous, active-low reset
//  - ctrl_DIV         in   1      start pulse; operands sampled on the same edge
//  - data_operandA    in   WIDTH  dividend, two's complement
//  - data_operandB    in   WIDTH  divisor, two's complement
//  - data_result      out  WIDTH  quotient, truncated toward zero
//  - data_exception   out  1      divide-by-zero flag, valid with data_resultRDY
//  - data_resultRDY   out  1      one-cycle pulse: result/exception valid
//  - data_busy        out  1      high from start edge until the RDY pulse
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE; data_result=0, data_exception=0, data_resultRDY=0,
//    data_busy=0; remainder, quotient and counter registers = 0. Takes effect mid-operation; no RDY follows.
//  - States: IDLE -> RUN -> FIXUP -> DONE -> IDLE; IDLE -> DONE directly for divisor zero.
//  - Start edge (ctrl_DIV=1): latch |A|, |B|, sign_q = A[W-1]^B[W-1], sign_r = A[W-1]; count=0.
//    If B==0 -> DONE with exception=1, result=0 (RDY 1 cycle after start edge).
//  - RUN, per edge: {R,Q} <<= 1; diff = R - |B| (WIDTH+1 bits via div_subtractor);
//    diff >= 0 -> R = diff, Q[0]=1; else Q[0]=0. Exactly WIDTH iterations.
//  - FIXUP: result = sign_q ? -Q : Q; remainder = sign_r ? -R : R; registered.
//  - DONE: data_resultRDY=1 for exactly one cycle, data_busy drops with it; state -> IDLE.
//  - Latency: RDY high in the cycle beginning WIDTH+2 edges after the start edge (34 for WIDTH=32).
//  - Outputs data_result/data_exception hold until the next start edge; exception cleared on start.
//  - |A| of most-negative value = 2^(W-1), held unsigned; 0x80000000 / -1 = 0x80000000, exception=0.
//  - ctrl_DIV while busy: abort current op, relatch operands, restart count; no RDY for aborted op.
//  - ctrl_DIV in the DONE cycle: RDY still pulses for the finished op; new op starts same edge.
//  - Division semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
// CONFIGURATION
//  - MULTDIV_DIV_REMAINDER_EN defined: adds port data_remainder out WIDTH (reset 0, valid with RDY,
//    held like data_result; 0 on divide-by-zero).
//  - Undefined: port absent, remainder negation in FIXUP omitted; R register still used internally.
// STRUCTURE
//  - multdiv_pkg: WIDTH default constant, div_state_t enum {IDLE,RUN,FIXUP,DONE}, CNT_W constant.
//  - Sub-module div_subtractor: WIDTH+1-bit subtract as A + ~B + 1, outputs diff and borrow;
//    lookahead-carry structure matching the multiplier adder blocks. One instance.
//  - Top: FSM, counter, R/Q shift registers, magnitude/negate logic, output registers.
// TESTING
//  - 100 / 7 -> result 14 (rem 2), exception 0, RDY exactly 34 cycles after start, busy high throughout.
//  - -100 / 7 -> result -14 (0xFFFFFFF2), rem -2; 100 / -7 -> -14, rem 2.
//  - 5 / 0 -> exception 1, result 0, RDY 1 cycle after start; next 9/3 -> 3, exception 0.
//  - 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 0; 0x80000000 / 1 -> 0x80000000.
//  - Start 1000/10, reassert ctrl_DIV at cycle 10 with 77/7 -> single RDY at cycle 10+34, result 11.
//  - Start 50/5, drop reset_n at cycle 20 -> all outputs 0 asynchronously, no RDY; restart gives 10.

Source files
------------

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants and state type for the multdiv divider
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_w(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_subtractor.sv
// rtl/div_subtractor.sv - N-bit subtract as a + ~b + 1 with parallel-prefix carry lookahead
module div_subtractor #(
  parameter int N = 33
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);

  // Kogge-Stone prefix over generate/propagate; carry-in is fixed at 1.
  function automatic logic [N:0] prefix_carries(input logic [N-1:0] g_in, input logic [N-1:0] p_in);
    logic [N-1:0] g, p, g_nx, p_nx;
    logic [N:0]   c;
    g = g_in;
    p = p_in;
    for (int d = 1; d < N; d = d * 2) begin
      g_nx = g;
      p_nx = p;
      for (int i = d; i < N; i++) begin
        g_nx[i] = g[i] | (p[i] & g[i-d]);
        p_nx[i] = p[i] & p[i-d];
      end
      g = g_nx;
      p = p_nx;
    end
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) c[i+1] = g[i] | p[i];
    return c;
  endfunction

  logic [N-1:0] w_b_n, w_g, w_p;
  logic [N:0]   w_c;

  assign w_b_n    = ~i_b;
  assign w_g      = i_a & w_b_n;
  assign w_p      = i_a ^ w_b_n;
  assign w_c      = prefix_carries(w_g, w_p);
  assign o_diff   = w_p ^ w_c[N-1:0];
  assign o_borrow = ~w_c[N];

endmodule

// File: rtl/multdiv_divider.sv
// rtl/multdiv_divider.sv - multicycle signed restoring divider, one quotient bit per cycle
// Optional remainder output enabled by defining MULTDIV_DIV_REMAINDER_EN.
module multdiv_divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
`ifdef MULTDIV_DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam int CW = cnt_w(WIDTH);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q, r_dz;
`ifdef MULTDIV_DIV_REMAINDER_EN
  logic [WIDTH-1:0] r_rem_fix;
  logic             r_sign_r;
`endif

  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_borrow, w_b_zero;

  // Most-negative operand magnitude 2^(W-1) stays correct when read as unsigned.
  assign w_mag_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_b_zero = (data_operandB == '0);
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};

  div_subtractor #(.N(WIDTH + 1)) u_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_rem          <= '0;
      r_quo          <= '0;
      r_dvs          <= '0;
      r_res          <= '0;
      r_cnt          <= '0;
      r_sign_q       <= 1'b0;
      r_dz           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
`ifdef MULTDIV_DIV_REMAINDER_EN
      r_rem_fix      <= '0;
      r_sign_r       <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;

      // Publish the finished op; a start in this same cycle overrides state/busy below.
      if (r_state == DONE) begin
        data_resultRDY <= 1'b1;
        data_busy      <= 1'b0;
        data_result    <= r_dz ? '0 : r_res;
        data_exception <= r_dz;
`ifdef MULTDIV_DIV_REMAINDER_EN
        data_remainder <= r_dz ? '0 : r_rem_fix;
`endif
        r_state        <= IDLE;
      end

      if (ctrl_DIV) begin
        r_rem     <= '0;
        r_quo     <= w_mag_a;
        r_dvs     <= w_mag_b;
        r_sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_dz      <= w_b_zero;
        r_cnt     <= '0;
        data_busy <= 1'b1;
        r_state   <= w_b_zero ? DONE : RUN;
`ifdef MULTDIV_DIV_REMAINDER_EN
        r_sign_r  <= data_operandA[WIDTH-1];
`endif
        if (r_state != DONE) data_exception <= 1'b0;
      end else begin
        case (r_state)
          RUN: begin
            r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) r_state <= FIXUP;
          end
          FIXUP: begin
            r_res     <= r_sign_q ? -r_quo : r_quo;
`ifdef MULTDIV_DIV_REMAINDER_EN
            r_rem_fix <= r_sign_r ? -r_rem : r_rem;
`endif
            r_state   <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_divider.sv
// tb/tb_multdiv_divider.sv - self-checking bench for multdiv_divider
module tb_multdiv_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] opa = '0, opb = '0;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, data_busy;
`ifdef MULTDIV_DIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif

  int checks = 0;
  int errors = 0;

  multdiv_divider dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
`ifdef MULTDIV_DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cur_rem();
`ifdef MULTDIV_DIV_REMAINDER_EN
    return data_remainder;
`else
    return 32'h0;
`endif
  endfunction

  // Reference: 64-bit signed arithmetic; SV / truncates toward zero and % follows the dividend.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa, sb;
    if (b == 32'h0) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      e = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic e, output int lat);
    logic busy_drop;
    busy_drop = 1'b0;
    lat = -1;
    q = '0; r = '0; e = 1'b0;
    @(negedge clock);
    opa = a; opb = b; ctrl_DIV = 1'b1;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
    chk("busy_after_start", data_busy, 1'b1);
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = n; q = data_result; r = cur_rem(); e = data_exception;
        chk("busy_low_at_rdy", data_busy, 1'b0);
        break;
      end else if (!data_busy) busy_drop = 1'b1;
    end
    if (lat < 0) chk("rdy_timeout", 1'b0, 1'b1);
    chk("busy_held", busy_drop, 1'b0);
    @(posedge clock);
    #1 chk("rdy_one_cycle", data_resultRDY, 1'b0);
  endtask

  task automatic check_result(input string nm, input logic [31:0] q, input logic [31:0] r,
                              input logic e, input int lat, input vec_t v);
    chk({nm, "_q"}, q, v.q);
    chk({nm, "_exc"}, e, v.e);
    chk({nm, "_lat"}, 64'(lat), 64'(v.lat));
`ifdef MULTDIV_DIV_REMAINDER_EN
    chk({nm, "_rem"}, r, v.r);
`endif
  endtask

  initial begin
    logic [31:0] q, r, mq, mr;
    logic        e, me;
    int          lat, rdy_cnt, first_n, second_n;
    logic [31:0] first_q, second_q;
    vec_t        v;

    vecs.push_back('{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34});
    vecs.push_back('{-32'sd100,    32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34});
    vecs.push_back('{32'd100,      -32'sd7,      32'hFFFFFFF2, 32'd2,        1'b0, 34});
    vecs.push_back('{32'd5,        32'd0,        32'd0,        32'd0,        1'b1, 1});
    vecs.push_back('{32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 34});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34});
    vecs.push_back('{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 34});
    vecs.push_back('{-32'sd7,      -32'sd2,      32'd3,        32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 34});
    vecs.push_back('{32'd7,        32'd8,        32'd0,        32'd7,        1'b0, 34});
    vecs.push_back('{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 34});
    vecs.push_back('{32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        1'b1, 1});
    vecs.push_back('{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 34});

    // Reset state
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_result", data_result, 32'h0);
    chk("reset_exc", data_exception, 1'b0);
    chk("reset_rdy", data_resultRDY, 1'b0);
    chk("reset_busy", data_busy, 1'b0);
`ifdef MULTDIV_DIV_REMAINDER_EN
    chk("reset_rem", data_remainder, 32'h0);
`endif
    @(negedge clock) reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, q, r, e, lat);
      check_result($sformatf("vec%0d", i), q, r, e, lat, vecs[i]);
    end

    for (int k = 0; k < 150; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = -$urandom_range(1, 1000);
        default: b = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(1, 15));
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      model(a, b, mq, mr, me);
      run_op(a, b, q, r, e, lat);
      v = '{a, b, mq, mr, me, (b == 32'h0) ? 1 : 34};
      check_result($sformatf("rnd%0d_%0h_%0h", k, a, b), q, r, e, lat, v);
    end

    // Restart while busy: only the second op reports
    rdy_cnt = 0; first_n = -1; first_q = '0;
    @(negedge clock);
    opa = 32'd1000; opb = 32'd10; ctrl_DIV = 1'b1;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 10) begin
        @(negedge clock);
        opa = 32'd77; opb = 32'd7; ctrl_DIV = 1'b1;
      end
      @(posedge clock);
      #1 ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (first_n < 0) begin first_n = n; first_q = data_result; end
      end
    end
    chk("abort_rdy_count", 64'(rdy_cnt), 64'd1);
    chk("abort_rdy_cycle", 64'(first_n), 64'd44);
    chk("abort_result", first_q, 32'd11);

    // Start in the DONE cycle: finished op still reports, new op follows
    rdy_cnt = 0; first_n = -1; second_n = -1; first_q = '0; second_q = '0;
    @(negedge clock);
    opa = 32'd100; opb = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (n == 34) begin
        @(negedge clock);
        opa = 32'd9; opb = 32'd3; ctrl_DIV = 1'b1;
      end
      @(posedge clock);
      #1 ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (first_n < 0) begin first_n = n; first_q = data_result; end
        else begin second_n = n; second_q = data_result; end
      end
    end
    chk("done_start_rdy_count", 64'(rdy_cnt), 64'd2);
    chk("done_start_first_cycle", 64'(first_n), 64'd34);
    chk("done_start_first_q", first_q, 32'd14);
    chk("done_start_second_cycle", 64'(second_n), 64'd68);
    chk("done_start_second_q", second_q, 32'd3);

    // Asynchronous reset mid-operation
    @(negedge clock);
    opa = 32'd50; opb = 32'd5; ctrl_DIV = 1'b1;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
    repeat (20) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_result", data_result, 32'h0);
    chk("midreset_exc", data_exception, 1'b0);
    chk("midreset_rdy", data_resultRDY, 1'b0);
    chk("midreset_busy", data_busy, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1 if (data_resultRDY) rdy_cnt++;
    end
    chk("midreset_no_rdy", 64'(rdy_cnt), 64'd0);
    run_op(32'd50, 32'd5, q, r, e, lat);
    v = '{32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34};
    check_result("after_reset", q, r, e, lat, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
